// File: rtl/register_file_if.sv
// Write-back / read-port bundle for register_file.
// master: the write-back and decode/execute side; slave: the register file.
interface register_file_if;
    logic        wr_en_i;
    logic        wr_long_en_i;
    logic [5:0]  wr_i_i;
    logic [3:0]  wr_hi_i_i;
    logic [31:0] wr_d_i;
    logic [63:0] wr_m_i;
    logic        cpsr_wr_en_i;
    logic [31:0] cpsr_i;
    logic [3:0]  ra_i_i;
    logic [3:0]  rb_i_i;
    logic [3:0]  rc_i_i;
    logic [31:0] ra_o;
    logic [31:0] rb_o;
    logic [31:0] rc_o;
    logic [31:0] pc_o;
    logic [31:0] cpsr_o;
    logic [31:0] spsr_o;
    logic        busy_o;

    modport master (
        output wr_en_i, wr_long_en_i, wr_i_i, wr_hi_i_i, wr_d_i, wr_m_i,
        output cpsr_wr_en_i, cpsr_i, ra_i_i, rb_i_i, rc_i_i,
        input  ra_o, rb_o, rc_o, pc_o, cpsr_o, spsr_o, busy_o
    );

    modport slave (
        input  wr_en_i, wr_long_en_i, wr_i_i, wr_hi_i_i, wr_d_i, wr_m_i,
        input  cpsr_wr_en_i, cpsr_i, ra_i_i, rb_i_i, rc_i_i,
        output ra_o, rb_o, rc_o, pc_o, cpsr_o, spsr_o, busy_o
    );
endinterface

// File: rtl/register_file.sv
// ARM architectural register file: 31 banked GPRs, CPSR and 5 SPSRs,
// three registered read ports, and a two-cycle long-multiply write sequencer.
// Optional macro REGISTER_FILE_BYPASS_EN: a read of the register being
// written on the same edge returns the new data instead of the old one.
//
// Physical GPR layout: 0..15 usr/sys r0..r15, 16..22 fiq r8..r14,
// 23/24 irq r13/r14, 25/26 svc, 27/28 abt, 29/30 und.
module register_file (
    input  logic            clk,
    input  logic            rst,
    register_file_if.slave  bus
);
    localparam logic [2:0] B_USR = 3'd0;
    localparam logic [2:0] B_FIQ = 3'd1;
    localparam logic [2:0] B_IRQ = 3'd2;
    localparam logic [2:0] B_SVC = 3'd3;
    localparam logic [2:0] B_ABT = 3'd4;
    localparam logic [2:0] B_UND = 3'd5;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_HI = 1'b1} state_t;

    // Unknown mode encodings (and sys) fall back to the user bank.
    function automatic logic [2:0] bank_of(input logic [4:0] m);
        case (m)
            5'b10001: bank_of = B_FIQ;
            5'b10010: bank_of = B_IRQ;
            5'b10011: bank_of = B_SVC;
            5'b10111: bank_of = B_ABT;
            5'b11011: bank_of = B_UND;
            default:  bank_of = B_USR;
        endcase
    endfunction

    function automatic logic [4:0] phys_of(input logic [2:0] bank, input logic [3:0] r);
        logic [4:0] p;
        p = {1'b0, r};
        if (bank == B_FIQ && r >= 4'd8 && r <= 4'd14) begin
            p = {1'b0, r} + 5'd8;
        end else if (r == 4'd13 || r == 4'd14) begin
            case (bank)
                B_IRQ:   p = r[0] ? 5'd23 : 5'd24;
                B_SVC:   p = r[0] ? 5'd25 : 5'd26;
                B_ABT:   p = r[0] ? 5'd27 : 5'd28;
                B_UND:   p = r[0] ? 5'd29 : 5'd30;
                default: p = {1'b0, r};
            endcase
        end
        phys_of = p;
    endfunction

    logic [31:0] gpr_q [0:30];
    logic [31:0] spsr_q [0:4];
    logic [31:0] cpsr_q;
    state_t      state_q, state_d;
    logic [3:0]  hi_idx_q;
    logic [31:0] hi_data_q;

    logic [2:0]  cur_bank;
    logic        gpr_we;
    logic [4:0]  gpr_wa;
    logic [31:0] gpr_wd;
    logic        spsr_we;
    logic [2:0]  spsr_wa;

    assign cur_bank = bank_of(cpsr_q[4:0]);

    // Select this cycle's GPR/SPSR write: pending high word, then long low word, then single word.
    always_comb begin
        gpr_we  = 1'b0;
        gpr_wa  = 5'd0;
        gpr_wd  = 32'd0;
        spsr_we = 1'b0;
        spsr_wa = 3'd0;
        if (state_q == S_HI) begin
            gpr_we = 1'b1;
            gpr_wa = phys_of(cur_bank, hi_idx_q);
            gpr_wd = hi_data_q;
        end else if (bus.wr_long_en_i) begin
            gpr_we = 1'b1;
            gpr_wa = phys_of(cur_bank, bus.wr_i_i[3:0]);
            gpr_wd = bus.wr_m_i[31:0];
        end else if (bus.wr_en_i) begin
            case (bus.wr_i_i[5:4])
                2'b00: begin
                    gpr_we = 1'b1;
                    gpr_wa = phys_of(cur_bank, bus.wr_i_i[3:0]);
                    gpr_wd = bus.wr_d_i;
                end
                2'b01: begin
                    gpr_we = 1'b1;
                    gpr_wa = phys_of(B_USR, bus.wr_i_i[3:0]);
                    gpr_wd = bus.wr_d_i;
                end
                2'b10: begin
                    spsr_we = (cur_bank != B_USR);
                    spsr_wa = cur_bank - 3'd1;
                end
                default: ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a long write always spends exactly one cycle in HI.
    always_comb begin
        state_d = S_IDLE;
        if (state_q == S_IDLE && bus.wr_long_en_i) state_d = S_HI;
    end

    // FSM output: busy only while the high word is pending.
    always_comb begin
        bus.busy_o = (state_q == S_HI);
    end

    // Capture the RdHi index and high word when a long write starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_idx_q  <= 4'd0;
            hi_data_q <= 32'd0;
        end else if (state_q == S_IDLE && bus.wr_long_en_i) begin
            hi_idx_q  <= bus.wr_hi_i_i;
            hi_data_q <= bus.wr_m_i[63:32];
        end
    end

    // GPR storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 31; i++) gpr_q[i] <= 32'd0;
        end else if (gpr_we) begin
            gpr_q[gpr_wa] <= gpr_wd;
        end
    end

    // SPSR storage and CPSR; CPSR write is independent of the GPR path.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) spsr_q[i] <= 32'd0;
            cpsr_q <= 32'h0000_00D3;
        end else begin
            if (spsr_we) spsr_q[spsr_wa] <= bus.wr_d_i;
            if (bus.cpsr_wr_en_i) cpsr_q <= bus.cpsr_i;
        end
    end

    logic [3:0] rd_idx [0:2];
    assign rd_idx[0] = bus.ra_i_i;
    assign rd_idx[1] = bus.rb_i_i;
    assign rd_idx[2] = bus.rc_i_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            logic [4:0]  rd_phys;
            logic [31:0] rd_q;
            assign rd_phys = phys_of(cur_bank, rd_idx[gi]);
            // Registered read port, banked by the mode at the start of the cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= 32'd0;
                end else begin
`ifdef REGISTER_FILE_BYPASS_EN
                    if (gpr_we && gpr_wa == rd_phys) rd_q <= gpr_wd;
                    else                             rd_q <= gpr_q[rd_phys];
`else
                    rd_q <= gpr_q[rd_phys];
`endif
                end
            end
        end
    endgenerate

    assign bus.ra_o   = g_rd[0].rd_q;
    assign bus.rb_o   = g_rd[1].rd_q;
    assign bus.rc_o   = g_rd[2].rd_q;
    assign bus.pc_o   = gpr_q[15];
    assign bus.cpsr_o = cpsr_q;
    assign bus.spsr_o = (cur_bank == B_USR) ? 32'd0 : spsr_q[cur_bank - 3'd1];
endmodule
